// File: rtl/axil_arb2.sv
// Two-master AXI4-Lite arbiter sharing one slave, round-robin, one transaction at a time.
// Define ARB_TIMEOUT_EN to add a response timeout that returns SLVERR to the owner.
module axil_arb2 #(
  parameter int ADDR_W         = 28,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   M0_AWADDR,
  input  logic [2:0]          M0_AWPROT,
  input  logic                M0_AWVALID,
  output logic                M0_AWREADY,
  input  logic [DATA_W-1:0]   M0_WDATA,
  input  logic [DATA_W/8-1:0] M0_WSTRB,
  input  logic                M0_WVALID,
  output logic                M0_WREADY,
  output logic [1:0]          M0_BRESP,
  output logic                M0_BVALID,
  input  logic                M0_BREADY,
  input  logic [ADDR_W-1:0]   M0_ARADDR,
  input  logic [2:0]          M0_ARPROT,
  input  logic                M0_ARVALID,
  output logic                M0_ARREADY,
  output logic [DATA_W-1:0]   M0_RDATA,
  output logic [1:0]          M0_RRESP,
  output logic                M0_RVALID,
  input  logic                M0_RREADY,
  input  logic [ADDR_W-1:0]   M1_AWADDR,
  input  logic [2:0]          M1_AWPROT,
  input  logic                M1_AWVALID,
  output logic                M1_AWREADY,
  input  logic [DATA_W-1:0]   M1_WDATA,
  input  logic [DATA_W/8-1:0] M1_WSTRB,
  input  logic                M1_WVALID,
  output logic                M1_WREADY,
  output logic [1:0]          M1_BRESP,
  output logic                M1_BVALID,
  input  logic                M1_BREADY,
  input  logic [ADDR_W-1:0]   M1_ARADDR,
  input  logic [2:0]          M1_ARPROT,
  input  logic                M1_ARVALID,
  output logic                M1_ARREADY,
  output logic [DATA_W-1:0]   M1_RDATA,
  output logic [1:0]          M1_RRESP,
  output logic                M1_RVALID,
  input  logic                M1_RREADY,
  output logic [ADDR_W-1:0]   S_AWADDR,
  output logic [2:0]          S_AWPROT,
  output logic                S_AWVALID,
  input  logic                S_AWREADY,
  output logic [DATA_W-1:0]   S_WDATA,
  output logic [DATA_W/8-1:0] S_WSTRB,
  output logic                S_WVALID,
  input  logic                S_WREADY,
  input  logic [1:0]          S_BRESP,
  input  logic                S_BVALID,
  output logic                S_BREADY,
  output logic [ADDR_W-1:0]   S_ARADDR,
  output logic [2:0]          S_ARPROT,
  output logic                S_ARVALID,
  input  logic                S_ARREADY,
  input  logic [DATA_W-1:0]   S_RDATA,
  input  logic [1:0]          S_RRESP,
  input  logic                S_RVALID,
  output logic                S_RREADY,
  output logic [1:0]          gnt
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP} state_e;

  state_e     state_q;
  logic       owner_q, rrPtr_q, awDone_q, wDone_q, isWrite_q;
  logic [1:0] gnt_q;

  logic wrReq0, wrReq1, req0, req1, pick, pickWrite;
  logic inWaddr, inWresp, inRaddr, inRresp, timedOut;
  logic awHs, wHs, arHs, bHs, rHs;
  logic oBready, oRready, oBvalid, oRvalid;
  logic [1:0] oBresp, oRresp;
  logic [DATA_W-1:0] oRdata;

  // A write needs both AW and W presented; write beats read inside one master.
  assign wrReq0    = M0_AWVALID & M0_WVALID;
  assign wrReq1    = M1_AWVALID & M1_WVALID;
  assign req0      = wrReq0 | M0_ARVALID;
  assign req1      = wrReq1 | M1_ARVALID;
  assign pick      = (req0 & req1) ? rrPtr_q : req1;
  assign pickWrite = pick ? wrReq1 : wrReq0;

  assign inWaddr = (state_q == WADDR);
  assign inWresp = (state_q == WRESP);
  assign inRaddr = (state_q == RADDR);
  assign inRresp = (state_q == RRESP);

`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign timedOut = (state_q != IDLE) && (cnt_q == 16'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) cnt_d = '0;
    else if (!timedOut)  cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = ^32'(TIMEOUT_CYCLES);
  assign timedOut      = 1'b0;
`endif

  assign oBready = owner_q ? M1_BREADY : M0_BREADY;
  assign oRready = owner_q ? M1_RREADY : M0_RREADY;

  // Slave side only sees the owner's channels while in the matching address state.
  assign S_AWVALID = inWaddr & ~awDone_q & ~timedOut;
  assign S_WVALID  = inWaddr & ~wDone_q & ~timedOut;
  assign S_ARVALID = inRaddr & ~timedOut;
  assign S_AWADDR  = inWaddr ? (owner_q ? M1_AWADDR : M0_AWADDR) : '0;
  assign S_AWPROT  = inWaddr ? (owner_q ? M1_AWPROT : M0_AWPROT) : '0;
  assign S_WDATA   = inWaddr ? (owner_q ? M1_WDATA : M0_WDATA) : '0;
  assign S_WSTRB   = inWaddr ? (owner_q ? M1_WSTRB : M0_WSTRB) : '0;
  assign S_ARADDR  = inRaddr ? (owner_q ? M1_ARADDR : M0_ARADDR) : '0;
  assign S_ARPROT  = inRaddr ? (owner_q ? M1_ARPROT : M0_ARPROT) : '0;
  assign S_BREADY  = inWresp & oBready & ~timedOut;
  assign S_RREADY  = inRresp & oRready & ~timedOut;

  assign awHs = S_AWVALID & S_AWREADY;
  assign wHs  = S_WVALID & S_WREADY;
  assign arHs = S_ARVALID & S_ARREADY;

  // After a timeout the arbiter itself answers with SLVERR on the owner's pending channel.
  assign oBvalid = (inWresp & S_BVALID & ~timedOut) | (timedOut & isWrite_q);
  assign oRvalid = (inRresp & S_RVALID & ~timedOut) | (timedOut & ~isWrite_q);
  assign oBresp  = timedOut ? 2'b10 : (inWresp ? S_BRESP : 2'b00);
  assign oRresp  = timedOut ? 2'b10 : (inRresp ? S_RRESP : 2'b00);
  assign oRdata  = (inRresp & ~timedOut) ? S_RDATA : '0;
  assign bHs     = oBvalid & oBready;
  assign rHs     = oRvalid & oRready;

  assign M0_AWREADY = ~owner_q & awHs;
  assign M1_AWREADY = owner_q & awHs;
  assign M0_WREADY  = ~owner_q & wHs;
  assign M1_WREADY  = owner_q & wHs;
  assign M0_ARREADY = ~owner_q & arHs;
  assign M1_ARREADY = owner_q & arHs;
  assign M0_BVALID  = ~owner_q & oBvalid;
  assign M1_BVALID  = owner_q & oBvalid;
  assign M0_BRESP   = owner_q ? 2'b00 : oBresp;
  assign M1_BRESP   = owner_q ? oBresp : 2'b00;
  assign M0_RVALID  = ~owner_q & oRvalid;
  assign M1_RVALID  = owner_q & oRvalid;
  assign M0_RRESP   = owner_q ? 2'b00 : oRresp;
  assign M1_RRESP   = owner_q ? oRresp : 2'b00;
  assign M0_RDATA   = owner_q ? '0 : oRdata;
  assign M1_RDATA   = owner_q ? oRdata : '0;

  assign gnt = gnt_q;

  // Grant is taken in IDLE and held until the owner's B or R handshake completes.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rrPtr_q   <= 1'b0;
      awDone_q  <= 1'b0;
      wDone_q   <= 1'b0;
      isWrite_q <= 1'b0;
      gnt_q     <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            owner_q   <= pick;
            rrPtr_q   <= ~pick;
            isWrite_q <= pickWrite;
            gnt_q     <= pick ? 2'b10 : 2'b01;
            awDone_q  <= 1'b0;
            wDone_q   <= 1'b0;
            state_q   <= pickWrite ? WADDR : RADDR;
          end
        end
        WADDR: begin
          if (bHs) begin
            state_q  <= IDLE;
            gnt_q    <= 2'b00;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
          end else begin
            if (awHs) awDone_q <= 1'b1;
            if (wHs)  wDone_q  <= 1'b1;
            if ((awDone_q | awHs) & (wDone_q | wHs)) state_q <= WRESP;
          end
        end
        WRESP: begin
          if (bHs) begin
            state_q  <= IDLE;
            gnt_q    <= 2'b00;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
          end
        end
        RADDR: begin
          if (rHs) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
          end else if (arHs) begin
            state_q <= RRESP;
          end
        end
        RRESP: begin
          if (rHs) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_arb2.sv
// Self-checking bench for axil_arb2 with a register-block slave model and a response scoreboard.
// Define ARB_TIMEOUT_EN to also exercise the timeout error path (TIMEOUT_CYCLES=8).
module tb_axil_arb2;

  logic ACLK, ARESET;

  logic [27:0] mAwaddr [2];
  logic [2:0]  mAwprot [2];
  logic [31:0] mWdata  [2];
  logic [3:0]  mWstrb  [2];
  logic [27:0] mAraddr [2];
  logic [2:0]  mArprot [2];
  logic [1:0]  mAwvalid, mWvalid, mBready, mArvalid, mRready;
  wire  [1:0]  mAwready, mWready, mBvalid, mArready, mRvalid;
  wire  [1:0]  mBresp [2];
  wire  [1:0]  mRresp [2];
  wire  [31:0] mRdata [2];

  wire  [27:0] S_AWADDR, S_ARADDR;
  wire  [2:0]  S_AWPROT, S_ARPROT;
  wire  [31:0] S_WDATA;
  wire  [3:0]  S_WSTRB;
  wire         S_AWVALID, S_WVALID, S_BREADY, S_ARVALID, S_RREADY;
  wire  [1:0]  gnt;
  logic        S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID;
  logic [1:0]  S_BRESP, S_RRESP;
  logic [31:0] S_RDATA;

  int total = 0;
  int bad   = 0;

  logic [59:0] expSlave [$];
  logic [1:0]  expB0 [$];
  logic [1:0]  expB1 [$];
  logic [31:0] expR0 [$];
  logic [31:0] expR1 [$];
  logic [1:0]  grantLog [$];
  logic [1:0]  gntPrev;
  logic [31:0] tbMem [16];

  logic        sAwReadyEn, sWReadyEn, sRespEn;
  logic        sAwGot, sWGot, sBvalid, sRvalid;
  logic [27:0] sAwAddr;
  logic [31:0] sWData, sRdata;
  logic [31:0] sMem [16];
  int          sAwCount;
  logic        awNow, wNow;
  logic [27:0] awAddrNow;
  logic [31:0] wDataNow;

  axil_arb2 #(.ADDR_W(28), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_AWADDR(mAwaddr[0]), .M0_AWPROT(mAwprot[0]), .M0_AWVALID(mAwvalid[0]), .M0_AWREADY(mAwready[0]),
    .M0_WDATA(mWdata[0]), .M0_WSTRB(mWstrb[0]), .M0_WVALID(mWvalid[0]), .M0_WREADY(mWready[0]),
    .M0_BRESP(mBresp[0]), .M0_BVALID(mBvalid[0]), .M0_BREADY(mBready[0]),
    .M0_ARADDR(mAraddr[0]), .M0_ARPROT(mArprot[0]), .M0_ARVALID(mArvalid[0]), .M0_ARREADY(mArready[0]),
    .M0_RDATA(mRdata[0]), .M0_RRESP(mRresp[0]), .M0_RVALID(mRvalid[0]), .M0_RREADY(mRready[0]),
    .M1_AWADDR(mAwaddr[1]), .M1_AWPROT(mAwprot[1]), .M1_AWVALID(mAwvalid[1]), .M1_AWREADY(mAwready[1]),
    .M1_WDATA(mWdata[1]), .M1_WSTRB(mWstrb[1]), .M1_WVALID(mWvalid[1]), .M1_WREADY(mWready[1]),
    .M1_BRESP(mBresp[1]), .M1_BVALID(mBvalid[1]), .M1_BREADY(mBready[1]),
    .M1_ARADDR(mAraddr[1]), .M1_ARPROT(mArprot[1]), .M1_ARVALID(mArvalid[1]), .M1_ARREADY(mArready[1]),
    .M1_RDATA(mRdata[1]), .M1_RRESP(mRresp[1]), .M1_RVALID(mRvalid[1]), .M1_RREADY(mRready[1]),
    .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .gnt(gnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] defaultMem(input int i);
    return (i == 1) ? 32'h1234_5678 : {16'hC0DE, 12'h000, 4'(i)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic slaveCommit(input logic [27:0] a, input logic [31:0] d);
    logic [59:0] e;
    checkOutput("slvPending", 32'(expSlave.size() > 0), 1);
    if (expSlave.size() > 0) begin
      e = expSlave.pop_front();
      checkOutput("slvAddr", 32'(a), 32'(e[59:32]));
      checkOutput("slvData", d, e[31:0]);
    end
  endtask

  // Register-block slave: AW/W/AR ready by default, B/R one cycle after the last handshake.
  assign S_AWREADY = sAwReadyEn;
  assign S_WREADY  = sWReadyEn;
  assign S_ARREADY = 1'b1;
  assign S_BVALID  = sBvalid;
  assign S_BRESP   = 2'b00;
  assign S_RVALID  = sRvalid;
  assign S_RDATA   = sRdata;
  assign S_RRESP   = 2'b00;
  assign awNow     = sAwGot | (S_AWVALID & S_AWREADY);
  assign wNow      = sWGot | (S_WVALID & S_WREADY);
  assign awAddrNow = sAwGot ? sAwAddr : S_AWADDR;
  assign wDataNow  = sWGot ? sWData : S_WDATA;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sAwGot <= 1'b0; sWGot <= 1'b0; sBvalid <= 1'b0; sRvalid <= 1'b0;
      sAwAddr <= '0; sWData <= '0; sRdata <= '0; sAwCount <= 0;
      for (int i = 0; i < 16; i++) sMem[i] <= defaultMem(i);
    end else begin
      if (S_AWVALID && S_AWREADY) sAwCount <= sAwCount + 1;
      if (sBvalid && S_BREADY) sBvalid <= 1'b0;
      if (awNow && wNow) begin
        sMem[awAddrNow[5:2]] <= wDataNow;
        slaveCommit(awAddrNow, wDataNow);
        sBvalid <= 1'b1;
        sAwGot  <= 1'b0;
        sWGot   <= 1'b0;
      end else begin
        if (S_AWVALID && S_AWREADY) begin sAwGot <= 1'b1; sAwAddr <= S_AWADDR; end
        if (S_WVALID && S_WREADY) begin sWGot <= 1'b1; sWData <= S_WDATA; end
      end
      if (sRvalid && S_RREADY) sRvalid <= 1'b0;
      if (S_ARVALID && S_ARREADY && sRespEn) begin
        sRvalid <= 1'b1;
        sRdata  <= sMem[S_ARADDR[5:2]];
      end
    end
  end

  always @(negedge ACLK) begin
    if (gnt != 2'b00 && gntPrev == 2'b00) grantLog.push_back(gnt);
    gntPrev <= gnt;
  end

  task automatic applyStimulus();
    ARESET = 1'b1;
    mAwvalid = '0; mWvalid = '0; mBready = '0; mArvalid = '0; mRready = '0;
    for (int i = 0; i < 2; i++) begin
      mAwaddr[i] = '0; mAwprot[i] = '0; mWdata[i] = '0; mWstrb[i] = '0;
      mAraddr[i] = '0; mArprot[i] = '0;
    end
    for (int i = 0; i < 16; i++) tbMem[i] = defaultMem(i);
    sAwReadyEn = 1'b1; sWReadyEn = 1'b1; sRespEn = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    grantLog.delete();
  endtask

  task automatic masterWrite(input int idx, input logic [27:0] addr, input logic [31:0] data);
    logic awD, wD, bD;
    logic [1:0] e;
    int cyc;
    if (idx == 0) expB0.push_back(2'b00); else expB1.push_back(2'b00);
    mAwaddr[idx] = addr; mWdata[idx] = data; mWstrb[idx] = 4'hF;
    mAwvalid[idx] = 1'b1; mWvalid[idx] = 1'b1; mBready[idx] = 1'b1;
    awD = 0; wD = 0; bD = 0; cyc = 0;
    while (!bD && cyc < 300) begin
      @(negedge ACLK);
      cyc++;
      if (mAwready[idx]) begin
        awD = 1;
        checkOutput($sformatf("wrGnt%0d", idx), 32'(gnt), 32'(2'b01 << idx));
      end
      if (mWready[idx]) wD = 1;
      if (mBvalid[idx]) begin
        bD = 1;
        checkOutput($sformatf("wrExp%0d", idx), 32'(idx == 0 ? expB0.size() : expB1.size()), 1);
        e = (idx == 0) ? expB0.pop_front() : expB1.pop_front();
        checkOutput($sformatf("bresp%0d", idx), 32'(mBresp[idx]), 32'(e));
      end
      @(posedge ACLK);
      #1;
      if (awD) mAwvalid[idx] = 1'b0;
      if (wD)  mWvalid[idx] = 1'b0;
    end
    mBready[idx] = 1'b0;
    if (!bD) checkOutput($sformatf("wrHang%0d", idx), 32'(bD), 1);
  endtask

  task automatic masterRead(input int idx, input logic [27:0] addr);
    logic arD, rD;
    logic [31:0] e;
    int cyc;
    if (idx == 0) expR0.push_back(tbMem[addr[5:2]]); else expR1.push_back(tbMem[addr[5:2]]);
    mAraddr[idx] = addr; mArvalid[idx] = 1'b1; mRready[idx] = 1'b1;
    arD = 0; rD = 0; cyc = 0;
    while (!rD && cyc < 300) begin
      @(negedge ACLK);
      cyc++;
      if (mArready[idx]) begin
        arD = 1;
        checkOutput($sformatf("rdGnt%0d", idx), 32'(gnt), 32'(2'b01 << idx));
      end
      if (mRvalid[idx]) begin
        rD = 1;
        checkOutput($sformatf("rdExp%0d", idx), 32'(idx == 0 ? expR0.size() : expR1.size()), 1);
        e = (idx == 0) ? expR0.pop_front() : expR1.pop_front();
        checkOutput($sformatf("rdata%0d", idx), mRdata[idx], e);
        checkOutput($sformatf("rresp%0d", idx), 32'(mRresp[idx]), 0);
      end
      @(posedge ACLK);
      #1;
      if (arD) mArvalid[idx] = 1'b0;
    end
    mRready[idx] = 1'b0;
    if (!rD) checkOutput($sformatf("rdHang%0d", idx), 32'(rD), 1);
  endtask

  initial begin
    logic early;
    int   awBase;
    gntPrev = 2'b00;

    // Reset state while ARESET is held
    ARESET = 1'b1;
    #2;
    checkOutput("rstGnt", 32'(gnt), 0);
    checkOutput("rstSlave", 32'({S_AWVALID, S_WVALID, S_ARVALID, S_BREADY, S_RREADY}), 0);
    checkOutput("rstMaster", 32'({mAwready, mWready, mArready, mBvalid, mRvalid}), 0);
    applyStimulus();

    // Single read with cycle-accurate checks
    mAraddr[0] = 28'h4; mArvalid[0] = 1'b1; mRready[0] = 1'b1;
    @(negedge ACLK);
    checkOutput("rd.c0.sarv", 32'(S_ARVALID), 0);
    @(negedge ACLK);
    checkOutput("rd.c1.sarv", 32'(S_ARVALID), 1);
    checkOutput("rd.c1.saraddr", 32'(S_ARADDR), 32'h4);
    checkOutput("rd.c1.gnt", 32'(gnt), 1);
    checkOutput("rd.c1.m1", 32'({mAwready[1], mWready[1], mArready[1], mBvalid[1], mRvalid[1]}), 0);
    @(posedge ACLK);
    #1 mArvalid[0] = 1'b0;
    @(negedge ACLK);
    checkOutput("rd.c2.rvalid", 32'(mRvalid[0]), 1);
    checkOutput("rd.c2.rdata", mRdata[0], 32'h1234_5678);
    checkOutput("rd.c2.rresp", 32'(mRresp[0]), 0);
    checkOutput("rd.c2.gnt", 32'(gnt), 1);
    checkOutput("rd.c2.m1", 32'({mAwready[1], mWready[1], mArready[1], mBvalid[1], mRvalid[1]}), 0);
    @(posedge ACLK);
    #1 mRready[0] = 1'b0;
    @(negedge ACLK);
    checkOutput("rd.c3.gnt", 32'(gnt), 0);
    checkOutput("rd.c3.rvalid", 32'(mRvalid[0]), 0);

    // Simultaneous writes: M0 first after reset, then M1, then read both back
    applyStimulus();
    expSlave.push_back({28'h0, 32'hAAAA_0000});
    expSlave.push_back({28'h4, 32'h5555_0000});
    tbMem[0] = 32'hAAAA_0000;
    tbMem[1] = 32'h5555_0000;
    fork
      masterWrite(0, 28'h0, 32'hAAAA_0000);
      masterWrite(1, 28'h4, 32'h5555_0000);
    join
    checkOutput("wrOrderLen", 32'(grantLog.size()), 2);
    if (grantLog.size() == 2) begin
      checkOutput("wrOrder0", 32'(grantLog[0]), 1);
      checkOutput("wrOrder1", 32'(grantLog[1]), 2);
    end
    masterRead(0, 28'h4);
    masterRead(1, 28'h0);

    // Back-to-back fairness with both masters reading continuously
    applyStimulus();
    fork
      begin for (int k = 0; k < 3; k++) masterRead(0, 28'(32'h8 + 4 * k)); end
      begin for (int k = 0; k < 3; k++) masterRead(1, 28'(32'h20 + 4 * k)); end
    join
    checkOutput("fairLen", 32'(grantLog.size()), 6);
    for (int k = 0; k < 6 && k < grantLog.size(); k++)
      checkOutput($sformatf("fair%0d", k), 32'(grantLog[k]), (k % 2) ? 2 : 1);

    // Split acceptance: AW in cycle 1, W in cycle 3, B in cycle 4
    applyStimulus();
    sWReadyEn = 1'b0;
    awBase = sAwCount;
    expSlave.push_back({28'h8, 32'hDEAD_BEEF});
    mAwaddr[0] = 28'h8; mWdata[0] = 32'hDEAD_BEEF; mWstrb[0] = 4'hF;
    mAwvalid[0] = 1'b1; mWvalid[0] = 1'b1; mBready[0] = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    checkOutput("sp.c1.valids", 32'({S_AWVALID, S_WVALID}), 32'b11);
    checkOutput("sp.c1.readies", 32'({mAwready[0], mWready[0]}), 32'b10);
    @(posedge ACLK);
    #1 mAwvalid[0] = 1'b0;
    @(negedge ACLK);
    checkOutput("sp.c2.valids", 32'({S_AWVALID, S_WVALID}), 32'b01);
    @(posedge ACLK);
    #1 sWReadyEn = 1'b1;
    @(negedge ACLK);
    checkOutput("sp.c3.wready", 32'(mWready[0]), 1);
    checkOutput("sp.c3.bvalid", 32'(mBvalid[0]), 0);
    @(posedge ACLK);
    #1 mWvalid[0] = 1'b0;
    @(negedge ACLK);
    checkOutput("sp.c4.bvalid", 32'(mBvalid[0]), 1);
    checkOutput("sp.c4.bresp", 32'(mBresp[0]), 0);
    checkOutput("sp.c4.swvalid", 32'(S_WVALID), 0);
    @(posedge ACLK);
    #1 mBready[0] = 1'b0;
    @(negedge ACLK);
    checkOutput("sp.c5.bvalid", 32'(mBvalid[0]), 0);
    checkOutput("sp.c5.gnt", 32'(gnt), 0);
    checkOutput("sp.awCount", 32'(sAwCount - awBase), 1);

    // Reset while in RRESP, then M1 is served
    applyStimulus();
    mAraddr[0] = 28'hC; mArvalid[0] = 1'b1; mRready[0] = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    @(posedge ACLK);
    #1 mArvalid[0] = 1'b0;
    @(negedge ACLK);
    checkOutput("mr.pre.rvalid", 32'(mRvalid[0]), 1);
    #1 ARESET = 1'b1;
    #1;
    checkOutput("mr.gnt", 32'(gnt), 0);
    checkOutput("mr.slave", 32'({S_AWVALID, S_WVALID, S_ARVALID, S_BREADY, S_RREADY}), 0);
    checkOutput("mr.master", 32'({mAwready, mWready, mArready, mBvalid, mRvalid}), 0);
    mRready[0] = 1'b0;
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    masterRead(1, 28'h10);

`ifdef ARB_TIMEOUT_EN
    // Slave never answers: SLVERR eight cycles after entering RADDR
    applyStimulus();
    sRespEn = 1'b0;
    early = 1'b0;
    mAraddr[0] = 28'h4; mArvalid[0] = 1'b1; mRready[0] = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    early |= mRvalid[0];
    @(posedge ACLK);
    #1 mArvalid[0] = 1'b0;
    repeat (7) begin
      @(negedge ACLK);
      early |= mRvalid[0];
    end
    checkOutput("to.early", 32'(early), 0);
    @(negedge ACLK);
    checkOutput("to.rvalid", 32'(mRvalid[0]), 1);
    checkOutput("to.rresp", 32'(mRresp[0]), 32'b10);
    checkOutput("to.rdata", mRdata[0], 0);
    checkOutput("to.srready", 32'(S_RREADY), 0);
    @(posedge ACLK);
    #1 mRready[0] = 1'b0;
    @(negedge ACLK);
    checkOutput("to.idle", 32'(gnt), 0);
    sRespEn = 1'b1;
`endif

    checkOutput("leftSlave", 32'(expSlave.size()), 0);
    checkOutput("leftResp", 32'(expB0.size() + expB1.size() + expR0.size() + expR1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_arb2.md
Name: axil_arb2

Overview:
- Two-master to one-slave AXI4-Lite arbiter. It shares a single peripheral AXI-Lite slave (register block with always-ready AW/W/AR and a 1-cycle B/R response) between the core data port (M0) and the debug/DMA port (M1).
- One transaction is outstanding at a time. Fairness between masters is round-robin.
- Grant is held from address issue until the response handshake completes.

Parameters:
- ADDR_W, 28: address width on all ports.
- DATA_W, 32: data width; strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 64: response timeout; used only when ARB_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- Mx_AWADDR/Mx_AWPROT/Mx_AWVALID  in  ADDR_W/3/1  write address from master x (x=0,1).
- Mx_AWREADY  out  1  write address accept to master x.
- Mx_WDATA/Mx_WSTRB/Mx_WVALID  in  DATA_W/DATA_W/8/1  write data from master x.
- Mx_WREADY  out  1  write data accept.
- Mx_BRESP/Mx_BVALID  out  2/1  write response to master x.
- Mx_BREADY  in  1.
- Mx_ARADDR/Mx_ARPROT/Mx_ARVALID  in  ADDR_W/3/1  read address.
- Mx_ARREADY  out  1.
- Mx_RDATA/Mx_RRESP/Mx_RVALID  out  DATA_W/2/1  read data/response.
- Mx_RREADY  in  1.
- S_AWADDR/S_AWPROT/S_AWVALID  out  ADDR_W/3/1  to slave.
- S_AWREADY  in  1.
- S_WDATA/S_WSTRB/S_WVALID  out  DATA_W/DATA_W/8/1.
- S_WREADY  in  1.
- S_BRESP/S_BVALID  in  2/1.
- S_BREADY  out  1.
- S_ARADDR/S_ARPROT/S_ARVALID  out  ADDR_W/3/1.
- S_ARREADY  in  1.
- S_RDATA/S_RRESP/S_RVALID  in  DATA_W/2/1.
- S_RREADY  out  1.
- gnt  out  2  one-hot current owner, for debug; 00 when idle.

Behaviour:
- Clock/reset: single clock ACLK; ARESET is asynchronous and active-high. Reset forces state=IDLE, rr_ptr=0 (M0 preferred), gnt=00, aw_done=w_done=0, and all VALID/READY outputs to 0. Reset mid-transaction abandons it silently; no response is returned.
- Requests: master x requests a write when Mx_AWVALID & Mx_WVALID, and a read when Mx_ARVALID. AW without W is not a request. Within one master, write wins over read.
- Arbitration (IDLE only):
  - If both masters request, grant the master selected by rr_ptr.
  - If only one requests, grant it.
  - On grant, rr_ptr <= granted index ^ 1.
  - Decision registered: request sampled at edge N → S_*VALID high from cycle N+1.
- FSM states:
  - IDLE → WADDR (write grant) or RADDR (read grant).
  - WADDR: S_AWVALID = ~aw_done, S_WVALID = ~w_done. Channels are muxed combinationally from the owner. The owner's Mx_AWREADY/Mx_WREADY mirror S_AWREADY/S_WREADY gated by the respective VALID. Each handshake sets its done flag; go to WRESP when both are done, including the same cycle.
  - WRESP: S_BREADY = owner Mx_BREADY; Mx_BVALID = S_BVALID, Mx_BRESP = S_BRESP. On B handshake → IDLE and clear flags.
  - RADDR: S_ARVALID=1; on S_ARREADY → RRESP.
  - RRESP: R channel passed through to owner; on R handshake → IDLE.
- Earliest re-arbitration is the cycle after response completion (IDLE lasts ≥1 cycle). Minimum write = 4 cycles request-to-next-grant; read also 4.
- Non-owner: all READY/VALID outputs 0. Its requests stay pending; AXI requires it to hold them stable.
- Idle slave outputs: addresses/data driven 0 when not in an address state.
- Owner must not drop VALID before handshake; behaviour is undefined otherwise and is not checked.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entering WADDR/RADDR and increments each cycle in any non-IDLE state. When it reaches TIMEOUT_CYCLES:
  - The arbiter stops driving the slave (S_*VALID=0, S_BREADY/S_RREADY=0).
  - It returns an error to the owner: BRESP or RRESP = 2'b10 (SLVERR), RDATA=0, VALID held until the owner's READY.
  - It then returns to IDLE.
  - A slave response arriving after the timeout is ignored; its READY is held low.
- Undefined: no counter, no error path; a stalled slave hangs the arbiter.

Test Plan:
- Single read: M0 ARADDR=0x4, slave RDATA=0x1234_5678 → S_ARVALID cycle 1, M0_RDATA=0x12345678 RRESP=00, gnt=01, M1 readies all 0.
- Simultaneous writes after reset: M0 writes 0xAAAA_0000 @0x0 and M1 writes 0x5555_0000 @0x4 → M0 served first, then M1; slave sees both writes in that order; each master gets BRESP=00.
- Back-to-back fairness: both masters request reads continuously for 6 transactions → grants alternate 01,10,01,10,01,10.
- Split write acceptance: slave S_AWREADY in cycle 1, S_WREADY in cycle 3 → AW issued once, WRESP entered in cycle 4, exactly one B to owner.
- Reset mid-read: assert ARESET while in RRESP → all VALID/READY 0 immediately (asynchronous); gnt=00; after release, the next M1 request is granted.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never asserts S_RVALID → M0_RVALID with RRESP=10, RDATA=0 eight cycles after entering RADDR; arbiter returns to IDLE.
